// File: rtl/music_pkg.sv
// rtl/music_pkg.sv - shared state type and default widths for the note sample source
package music_pkg;

    localparam int PHASE_W    = 22;
    localparam int ROM_ADDR_W = 10;
    localparam int DUR_W      = 6;
    localparam int SAMPLE_W   = 16;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

endpackage

// File: rtl/sine_lookup.sv
// rtl/sine_lookup.sv - phase accumulator and three-stage quarter-wave sine fetch pipeline
module sine_lookup
    import music_pkg::SAMPLE_W;
#(
    parameter int PHASE_W    = music_pkg::PHASE_W,
    parameter int ROM_ADDR_W = music_pkg::ROM_ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  playing,
    input  logic                  phase_clear,
    input  logic [PHASE_W-3:0]    step,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    input  logic [SAMPLE_W-1:0]   rom_data,
    output logic [SAMPLE_W-1:0]   sample_out,
    output logic                  sample_valid,
    output logic                  overrun
);

    logic [PHASE_W-1:0]    phase;
    logic [PHASE_W-1:0]    phase_nxt;
    logic [ROM_ADDR_W-1:0] off;
    logic                  busy;
    logic                  take;
    logic                  mute;
    logic                  s1_valid;
    logic                  s1_neg;
    logic                  s1_mute;
    logic                  s2_valid;
    logic                  s2_neg;
    logic                  s2_mute;

    // Decode a new request: accept only when no fetch is between address and ROM data,
    // advance the phase only while a note plays, and mute rests and idle requests.
    always_comb begin
        busy      = s1_valid || s2_valid;
        take      = req && !busy;
        phase_nxt = playing ? (phase + {2'b00, step}) : phase;
        off       = phase_nxt[PHASE_W-3 -: ROM_ADDR_W];
        mute      = !playing || (step == '0);
    end

    // Address stage, ROM wait stage and sign/output stage; quadrant sign and mute ride along.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase        <= '0;
            rom_addr     <= '0;
            s1_valid     <= 1'b0;
            s1_neg       <= 1'b0;
            s1_mute      <= 1'b0;
            s2_valid     <= 1'b0;
            s2_neg       <= 1'b0;
            s2_mute      <= 1'b0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            s1_valid     <= take;
            s2_valid     <= s1_valid;
            sample_valid <= s2_valid;

            if (phase_clear) begin
                phase <= '0;
            end else if (take) begin
                phase <= phase_nxt;
            end

            if (take) begin
                rom_addr <= phase_nxt[PHASE_W-2] ? ~off : off;
                s1_neg   <= phase_nxt[PHASE_W-1];
                s1_mute  <= mute;
            end

            if (s1_valid) begin
                s2_neg  <= s1_neg;
                s2_mute <= s1_mute;
            end

            if (s2_valid) begin
                sample_out <= s2_mute ? '0 : (s2_neg ? -rom_data : rom_data);
            end

            if (req && busy) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/note_sample_source.sv
// rtl/note_sample_source.sv - note FSM, note latch and beat counter around the sine fetch pipeline
module note_sample_source
    import music_pkg::state_t;
    import music_pkg::IDLE;
    import music_pkg::PLAY;
    import music_pkg::SAMPLE_W;
#(
    parameter int PHASE_W    = music_pkg::PHASE_W,
    parameter int ROM_ADDR_W = music_pkg::ROM_ADDR_W,
    parameter int DUR_W      = music_pkg::DUR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  play,
    input  logic                  note_valid,
    output logic                  note_ready,
    input  logic [PHASE_W-3:0]    note_step,
    input  logic [DUR_W-1:0]      note_dur,
    input  logic                  beat,
    input  logic                  generate_next_sample,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    input  logic [SAMPLE_W-1:0]   rom_data,
    output logic [SAMPLE_W-1:0]   sample_out,
    output logic                  new_sample_ready,
    output logic [DUR_W-1:0]      note_duration,
    output logic                  done_with_note,
    output logic                  overrun
);

    state_t             state;
    state_t             state_nxt;
    logic [PHASE_W-3:0] step_q;
    logic [DUR_W-1:0]   dur_q;
    logic [DUR_W-1:0]   beat_cnt;
    logic               accept;
    logic               note_end;
    logic               last_beat;
    logic               playing;

    assign playing = (state == PLAY);

    // Next state, handshake and note-end decode; note_ready is held low while in reset.
    always_comb begin
        state_nxt  = state;
        note_ready = 1'b0;
        accept     = 1'b0;
        note_end   = 1'b0;
        last_beat  = beat && (beat_cnt == dur_q - DUR_W'(1));
        case (state)
            IDLE: begin
                note_ready = play && reset;
                accept     = note_valid && note_ready;
                if (accept) begin
                    if (note_dur == '0) begin
                        note_end = 1'b1;
                    end else begin
                        state_nxt = PLAY;
                    end
                end
            end
            PLAY: begin
                if (!play || last_beat) begin
                    note_end  = 1'b1;
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Note latch, beat counter and note-timing outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step_q         <= '0;
            dur_q          <= '0;
            beat_cnt       <= '0;
            note_duration  <= '0;
            done_with_note <= 1'b0;
        end else begin
            done_with_note <= note_end;
            if (accept) begin
                step_q        <= note_step;
                dur_q         <= note_dur;
                beat_cnt      <= '0;
                note_duration <= note_dur;
            end else if (state == PLAY) begin
                if (note_end) begin
                    beat_cnt      <= '0;
                    note_duration <= '0;
                end else if (beat) begin
                    beat_cnt <= beat_cnt + DUR_W'(1);
                end
            end
        end
    end

    sine_lookup #(
        .PHASE_W    (PHASE_W),
        .ROM_ADDR_W (ROM_ADDR_W)
    ) u_sine_lookup (
        .clk          (clk),
        .reset        (reset),
        .req          (generate_next_sample),
        .playing      (playing),
        .phase_clear  (accept),
        .step         (step_q),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .sample_out   (sample_out),
        .sample_valid (new_sample_ready),
        .overrun      (overrun)
    );

endmodule

// File: tb/tb_note_sample_source.sv
// tb/tb_note_sample_source.sv - directed table-driven bench for note_sample_source
module tb_note_sample_source;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        play = 1'b0;
    logic        note_valid = 1'b0;
    logic        note_ready;
    logic [19:0] note_step = '0;
    logic [5:0]  note_dur = '0;
    logic        beat = 1'b0;
    logic        generate_next_sample = 1'b0;
    logic [9:0]  rom_addr;
    logic [15:0] rom_data = '0;
    logic [15:0] sample_out;
    logic        new_sample_ready;
    logic [5:0]  note_duration;
    logic        done_with_note;
    logic        overrun;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [19:0] step;
        int          e0;
        int          e1;
        int          e2;
        int          e3;
    } vec_t;

    vec_t vt[5];

    note_sample_source dut (
        .clk                  (clk),
        .reset                (reset),
        .play                 (play),
        .note_valid           (note_valid),
        .note_ready           (note_ready),
        .note_step            (note_step),
        .note_dur             (note_dur),
        .beat                 (beat),
        .generate_next_sample (generate_next_sample),
        .rom_addr             (rom_addr),
        .rom_data             (rom_data),
        .sample_out           (sample_out),
        .new_sample_ready     (new_sample_ready),
        .note_duration        (note_duration),
        .done_with_note       (done_with_note),
        .overrun              (overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom_fn(input logic [9:0] a);
        if (a == 10'd1023) return 16'd32767;
        return 16'({a, 5'b00000});
    endfunction

    // external quarter-wave ROM: one cycle read latency
    always @(posedge clk) rom_data <= rom_fn(rom_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic start_note(input string name, input logic [19:0] step, input logic [5:0] dur);
        note_step  = step;
        note_dur   = dur;
        note_valid = 1'b1;
        chk({name, "_ready"}, note_ready, 1);
        tick();
        note_valid = 1'b0;
        chk({name, "_dur"}, note_duration, int'(dur));
    endtask

    task automatic do_req(input string name, input int exp);
        generate_next_sample = 1'b1;
        tick();
        generate_next_sample = 1'b0;
        chk({name, "_n1"}, new_sample_ready, 0);
        tick();
        chk({name, "_n2"}, new_sample_ready, 0);
        tick();
        chk({name, "_pulse"}, new_sample_ready, 1);
        chk({name, "_sample"}, int'($signed(sample_out)), exp);
        tick();
        chk({name, "_n4"}, new_sample_ready, 0);
    endtask

    task automatic abort_note(input string name);
        play = 1'b0;
        tick();
        chk({name, "_done"}, done_with_note, 1);
        chk({name, "_dur0"}, note_duration, 0);
        play = 1'b1;
        tick();
        chk({name, "_done_clr"}, done_with_note, 0);
    endtask

    initial begin
        int ev[4];
        int cnt;

        vt[0] = '{step: 20'hFFFFF, e0: 32767, e1: 0,     e2: -32767, e3: 0};
        vt[1] = '{step: 20'h01000, e0: 128,   e1: 256,   e2: 384,    e3: 512};
        vt[2] = '{step: 20'hC0000, e0: 24576, e1: 16352, e2: -8192,  e3: -32767};
        vt[3] = '{step: 20'h00000, e0: 0,     e1: 0,     e2: 0,      e3: 0};
        vt[4] = '{step: 20'hFFC00, e0: 32767, e1: 32,    e2: -32672, e3: -96};

        // reset held with play high
        play = 1'b1;
        repeat (3) tick();
        chk("rst_ready", note_ready, 0);
        chk("rst_sample", sample_out, 0);
        chk("rst_nsr", new_sample_ready, 0);
        chk("rst_dur", note_duration, 0);
        chk("rst_done", done_with_note, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_addr", rom_addr, 0);
        reset = 1'b1;
        #1;
        chk("rel_ready", note_ready, 1);
        tick();

        // table: one note per vector, four requests each, then abort
        for (int i = 0; i < 5; i++) begin
            ev[0] = vt[i].e0;
            ev[1] = vt[i].e1;
            ev[2] = vt[i].e2;
            ev[3] = vt[i].e3;
            start_note($sformatf("v%0d", i), vt[i].step, 6'd8);
            for (int j = 0; j < 4; j++) begin
                do_req($sformatf("v%0d_r%0d", i, j), ev[j]);
                repeat (2) tick();
            end
            abort_note($sformatf("v%0d_abort", i));
        end

        // beat counting: dur 3, beats at relative cycles 2, 5, 9
        start_note("beat", 20'h01000, 6'd3);
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("beat_done_k%0d", k), done_with_note, (k == 10) ? 1 : 0);
            chk($sformatf("beat_dur_k%0d", k), note_duration, (k < 10) ? 3 : 0);
            chk($sformatf("beat_ready_k%0d", k), note_ready, (k >= 10) ? 1 : 0);
            beat = (k == 2 || k == 5 || k == 9);
            tick();
        end
        beat = 1'b0;

        // final beat and request in the same cycle
        start_note("fin", 20'hFFFFF, 6'd1);
        beat = 1'b1;
        generate_next_sample = 1'b1;
        tick();
        beat = 1'b0;
        generate_next_sample = 1'b0;
        chk("fin_done", done_with_note, 1);
        chk("fin_dur0", note_duration, 0);
        chk("fin_n1", new_sample_ready, 0);
        tick();
        tick();
        chk("fin_pulse", new_sample_ready, 1);
        chk("fin_sample", int'($signed(sample_out)), 32767);
        tick();

        // handshake and request in the same cycle: silent sample, then phase restarts at 0
        note_step = 20'hFFFFF;
        note_dur = 6'd8;
        note_valid = 1'b1;
        generate_next_sample = 1'b1;
        tick();
        note_valid = 1'b0;
        generate_next_sample = 1'b0;
        chk("hs_dur", note_duration, 8);
        tick();
        tick();
        chk("hs_pulse", new_sample_ready, 1);
        chk("hs_sample", int'($signed(sample_out)), 0);
        tick();
        do_req("hs_next", 32767);
        abort_note("hs_abort");

        // request while idle is silent
        do_req("idle_req", 0);

        // zero-length note
        start_note("dur0", 20'hFFFFF, 6'd0);
        chk("dur0_done", done_with_note, 1);
        chk("dur0_ready", note_ready, 1);
        tick();
        chk("dur0_done_clr", done_with_note, 0);

        // back-to-back at the delivery cycle is accepted; one cycle later is dropped
        start_note("ovr", 20'hFFFFF, 6'd8);
        chk("ovr_clear", overrun, 0);
        generate_next_sample = 1'b1;
        tick();
        generate_next_sample = 1'b0;
        tick();
        tick();
        chk("b2b_p1", new_sample_ready, 1);
        chk("b2b_s1", int'($signed(sample_out)), 32767);
        generate_next_sample = 1'b1;
        tick();
        generate_next_sample = 1'b0;
        tick();
        tick();
        chk("b2b_p2", new_sample_ready, 1);
        chk("b2b_s2", int'($signed(sample_out)), 0);
        chk("b2b_ovr", overrun, 0);
        tick();
        generate_next_sample = 1'b1;
        tick();
        tick();
        generate_next_sample = 1'b0;
        chk("ovr_set", overrun, 1);
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            if (new_sample_ready) cnt++;
            tick();
        end
        chk("ovr_pulses", cnt, 1);
        chk("ovr_sample", int'($signed(sample_out)), -32767);
        repeat (5) tick();
        chk("ovr_sticky", overrun, 1);
        abort_note("ovr_abort");

        // reset mid-note with a fetch in flight
        start_note("rst", 20'hFFFFF, 6'd8);
        generate_next_sample = 1'b1;
        tick();
        generate_next_sample = 1'b0;
        reset = 1'b0;
        #1;
        chk("mid_ready", note_ready, 0);
        chk("mid_sample", sample_out, 0);
        chk("mid_nsr", new_sample_ready, 0);
        chk("mid_dur", note_duration, 0);
        chk("mid_done", done_with_note, 0);
        chk("mid_ovr", overrun, 0);
        chk("mid_addr", rom_addr, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("mid_hold_done%0d", k), done_with_note, 0);
            chk($sformatf("mid_hold_nsr%0d", k), new_sample_ready, 0);
        end
        reset = 1'b1;
        #1;
        chk("mid_rel_ready", note_ready, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("mid_rel_nsr%0d", k), new_sample_ready, 0);
            chk($sformatf("mid_rel_done%0d", k), done_with_note, 0);
        end
        start_note("after", 20'hFFFFF, 6'd8);
        do_req("after_req", 32767);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
